// File: rtl/regfile_sb_if.sv
// Register file bus: decode/issue read and scoreboard side plus writeback side.
// The master drives addresses, writeback and issue; the slave (register file)
// returns read data, hazards and the busy count.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rs_data;
  logic [NUM_READ-1:0]            rs_hazard;
  logic                           we;
  logic [ADDR_WIDTH-1:0]          rd;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           wb_clear;
  logic                           issue_valid;
  logic [ADDR_WIDTH-1:0]          issue_rd;
  logic [ADDR_WIDTH:0]            busy_count;

  modport master (
    output rs_addr, we, rd, write_data, wb_clear, issue_valid, issue_rd,
    input  rs_data, rs_hazard, busy_count
  );

  modport slave (
    input  rs_addr, we, rd, write_data, wb_clear, issue_valid, issue_rd,
    output rs_data, rs_hazard, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard.
// x0 is hardwired to zero and never busy. Reads can forward same-cycle
// writeback data (BYPASS) and can be combinational or registered (REG_READ).
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit BYPASS     = 1'b1,
  parameter bit REG_READ   = 1'b0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;
  logic [ADDR_WIDTH:0]              busy_count_q, busy_count_d;

  logic                             wr_en_s;
  logic                             set_s;
  logic                             clr_s;
  logic                             inc_s;
  logic                             dec_s;

  logic [NUM_READ*DATA_WIDTH-1:0]   rs_data_d;
  logic [NUM_READ-1:0]              rs_hazard_d;

  // Decode the writeback / issue strobes; x0 never participates.
  always_comb begin
    wr_en_s = bus.we && (bus.rd != {ADDR_WIDTH{1'b0}});
    set_s   = bus.issue_valid && (bus.issue_rd != {ADDR_WIDTH{1'b0}});
    clr_s   = wr_en_s && bus.wb_clear;
  end

  // Next register contents: single write port, x0 left untouched.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[bus.rd] = bus.write_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Next busy vector and count; a same-register set overrides the clear.
  always_comb begin
    busy_d = busy_q;
    inc_s  = set_s && !busy_q[bus.issue_rd];
    dec_s  = clr_s && busy_q[bus.rd] && !(set_s && (bus.issue_rd == bus.rd));
    if (clr_s) begin
      busy_d[bus.rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_s) begin
      busy_d[bus.issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_count_d = busy_count_q
                 + {{ADDR_WIDTH{1'b0}}, inc_s}
                 - {{ADDR_WIDTH{1'b0}}, dec_s};
  end

  // Register array, scoreboard and busy counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q       <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Per-port read selection with optional writeback forwarding; a forwarded
  // clear also suppresses the hazard because the value is already here.
  always_comb begin
    rs_data_d   = '0;
    rs_hazard_d = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rs_data_d[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[bus.rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      rs_hazard_d[k] = busy_q[bus.rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS && wr_en_s && (bus.rd == bus.rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rs_data_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
        if (bus.wb_clear) begin
          rs_hazard_d[k] = 1'b0;
        end else begin
          rs_hazard_d[k] = busy_q[bus.rd];
        end
      end else begin
        rs_hazard_d[k] = busy_q[bus.rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  assign bus.busy_count = busy_count_q;

  if (REG_READ) begin : g_reg_read
    logic [NUM_READ*DATA_WIDTH-1:0] rs_data_q;
    logic [NUM_READ-1:0]            rs_hazard_q;

    // Capture read data and hazard together for one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rs_data_q   <= '0;
        rs_hazard_q <= '0;
      end else begin
        rs_data_q   <= rs_data_d;
        rs_hazard_q <= rs_hazard_d;
      end
    end

    assign bus.rs_data   = rs_data_q;
    assign bus.rs_hazard = rs_hazard_q;
  end else begin : g_comb_read
    assign bus.rs_data   = rs_data_d;
    assign bus.rs_hazard = rs_hazard_d;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised next-generation integer register file for the RV32I core family.
- Configurable width, depth and number of read ports.
- Selectable write-to-read bypass and selectable combinational or registered read.
- Per-register busy scoreboard: pending writebacks from multicycle/pipelined issue raise hazards on dependent reads.
- Sits between decode/issue (read, issue_*) and writeback (we, rd, write_data).

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
BYPASS, 1, 1 = read of a register being written this cycle returns write_data; 0 = returns old data
REG_READ, 0, 0 = combinational read; 1 = read data and hazard registered, 1-cycle latency

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
rs_addr  input  NUM_READ*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rs_data  output  NUM_READ*DATA_WIDTH  read data, same packing
rs_hazard  output  NUM_READ  1 = addressed register has a pending write
we  input  1  writeback enable
rd  input  ADDR_WIDTH  writeback register index
write_data  input  DATA_WIDTH  writeback data
wb_clear  input  1  writeback also retires the scoreboard entry for rd
issue_valid  input  1  instruction issued that will write issue_rd
issue_rd  input  ADDR_WIDTH  destination of issued instruction
busy_count  output  ADDR_WIDTH+1  number of registers currently busy

Behaviour:
Reset (rst low, async, any time):
- All registers 0, all busy bits 0, busy_count 0.
- With REG_READ=1, the rs_data/rs_hazard registers are also 0.
- Reset mid-operation discards all pending state; there is no drain.

Register 0:
- Always reads 0 and is never written.
- Never marked busy; issue_rd=0 is ignored; hazard for address 0 is always 0.

Write:
- On posedge, if we && rd!=0, reg[rd] <= write_data.

Read, REG_READ=0 (combinational):
- rs_data[k] = reg[rs_addr[k]].
- If BYPASS=1 and we && rd!=0 && rd==rs_addr[k], rs_data[k] = write_data.

Read, REG_READ=1:
- The same selection is captured at posedge; data is valid the cycle after the address.
- BYPASS=1 captures write_data on a same-cycle match. BYPASS=0 captures the pre-write value.

Scoreboard (one busy bit per register 1..2**ADDR_WIDTH-1):
- set = issue_valid && issue_rd!=0.
- clr = we && wb_clear && rd!=0.
- Same register set and clr in the same cycle: set wins (new producer); busy stays 1.
- Set on an already-busy register: stays 1, no count change.
- Clr on a non-busy register: no effect, no count change.

Hazard:
- rs_hazard[k] = busy[rs_addr[k]], except 0 when BYPASS=1 and clr targets rs_addr[k] this cycle (value forwarded).
- Issue in the same cycle does not raise the hazard until the next cycle.
- With REG_READ=1 the hazard is registered alongside the data.

busy_count:
- Registered; updated each posedge by +1 for an effective 0->1 transition and -1 for an effective 1->0 transition.
- Both on different registers: net 0.
- Always equals the popcount of the busy bits; cannot exceed 2**ADDR_WIDTH-1 and cannot underflow.

Port independence:
- Read ports are fully independent; identical addresses on multiple ports are legal.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst low mid-cycle -> rs_data for x5 reads 0 immediately (async); busy_count=0.
- x0 protection: we=1, rd=0, write_data=0x12345678, issue_valid=1, issue_rd=0 -> x0 reads 0, rs_hazard=0, busy_count=0.
- Bypass: BYPASS=1, REG_READ=0; we=1, rd=7, data=0xA5A5A5A5 with rs_addr[0]=7 -> rs_data[0]=0xA5A5A5A5 the same cycle. BYPASS=0 -> old value 0 that cycle, 0xA5A5A5A5 the next.
- Scoreboard: issue x3 -> next cycle rs_hazard=1 for rs=3, busy_count=1. Writeback x3 with wb_clear and data 0x55 -> with BYPASS=1, hazard=0 and data=0x55 that cycle; busy_count=0 the next cycle.
- Simultaneous set/clear: x9 busy; same cycle issue_rd=9 and wb_clear rd=9 -> busy[9] stays 1, busy_count unchanged. Issue x4 while clearing x9 -> busy_count unchanged, busy[4]=1, busy[9]=0.
- REG_READ=1, NUM_READ=3: addresses 1,2,1 with x1=0x11, x2=0x22 -> next cycle rs_data = {0x11,0x22,0x11}; fill all 31 registers busy -> busy_count=31.
